// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: response codes and FSM state types shared by the AXI memory slave.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wState_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rState_e;

endpackage

// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI-style burst bus between a master and axi_mem_slave.
interface axi_mem_slave_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_W-1:0]       aw_id;
  logic [ADDR_W-1:0]     aw_addr;
  logic [7:0]            aw_len;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  w_last;
  logic                  b_valid;
  logic                  b_ready;
  logic [ID_W-1:0]       b_id;
  logic [1:0]            b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_W-1:0]       ar_id;
  logic [ADDR_W-1:0]     ar_addr;
  logic [7:0]            ar_len;
  logic                  r_valid;
  logic                  r_ready;
  logic [ID_W-1:0]       r_id;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready, ar_valid, ar_id, ar_addr, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp,
    output ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len,
    output w_valid, w_data, w_strb, w_last,
    output b_ready, ar_valid, ar_id, ar_addr, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp,
    input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

endinterface

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: DEPTH x DATA_W storage, one byte-enabled write port and one registered read port.
// A read and write of the same word on one edge returns the pre-write contents.
module axi_mem_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [STRB_W-1:0] wrStrb,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wrStrb[b]) mem[wrAddr][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI-style INCR-burst memory slave with independent read and write FSMs.
// Define AXI_MEM_SLAVE_BACKPRESSURE_EN to throttle aw/w/ar readies with a free-running LFSR.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 256
) (
  input logic            clock,
  input logic            reset,
  axi_mem_slave_if.slave bus
);

  // state  | meaning
  // W_IDLE | waiting for a write address
  // W_DATA | accepting write beats
  // W_RESP | presenting the write response
  // R_IDLE | waiting for a read address
  // R_DATA | presenting read beats, one per r handshake

  localparam int STRB_W = DATA_W / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFFS;
  localparam int RAM_AW = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(DEPTH);

  wState_e           wState, wStateNext;
  rState_e           rState, rStateNext;
  logic              throttle;
  logic              awHs, wHs, bHs, arHs, rHs;
  logic [IDX_W-1:0]  wIdx, rIdx, rdIdxNext;
  logic [7:0]        wLeft, rLeft;
  logic [ID_W-1:0]   wIdReg, rIdReg;
  logic              wErr, rOob;
  logic              wBeatOob, wLastBeat, wBeatErr, rLastBeat;
  logic              ramWrEn, ramRdEn;
  logic [DATA_W-1:0] ramRdData;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{bus.aw_addr[OFFS-1:0], bus.ar_addr[OFFS-1:0]};

`ifdef AXI_MEM_SLAVE_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign throttle = lfsr[0];
`else
  assign throttle = 1'b1;
`endif

  // Idle states would otherwise advertise ready while reset is still held.
  assign bus.aw_ready = ~reset & throttle & (wState == W_IDLE);
  assign bus.w_ready  = ~reset & throttle & (wState == W_DATA);
  assign bus.b_valid  = (wState == W_RESP);
  assign bus.ar_ready = ~reset & throttle & (rState == R_IDLE);
  assign bus.r_valid  = (rState == R_DATA);

  assign awHs = bus.aw_valid & bus.aw_ready;
  assign wHs  = bus.w_valid & bus.w_ready;
  assign bHs  = bus.b_valid & bus.b_ready;
  assign arHs = bus.ar_valid & bus.ar_ready;
  assign rHs  = bus.r_valid & bus.r_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wState <= W_IDLE;
      rState <= R_IDLE;
    end else begin
      wState <= wStateNext;
      rState <= rStateNext;
    end
  end

  always_comb begin
    wStateNext = wState;
    rStateNext = rState;
    unique case (wState)
      W_IDLE:  if (awHs) wStateNext = W_DATA;
      W_DATA:  if (wHs && wLastBeat) wStateNext = W_RESP;
      W_RESP:  if (bHs) wStateNext = W_IDLE;
      default: wStateNext = W_IDLE;
    endcase
    unique case (rState)
      R_IDLE:  if (arHs) rStateNext = R_DATA;
      R_DATA:  if (rHs && rLastBeat) rStateNext = R_IDLE;
      default: rStateNext = R_IDLE;
    endcase
  end

  // Write path: the beat count, not w_last, closes the burst.
  assign wBeatOob  = (wIdx >= LIMIT);
  assign wLastBeat = (wLeft == 8'd0);
  assign wBeatErr  = wBeatOob | (bus.w_last != wLastBeat);
  assign ramWrEn   = wHs & ~wBeatOob;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wIdx   <= '0;
      wLeft  <= '0;
      wIdReg <= '0;
      wErr   <= 1'b0;
    end else if (awHs) begin
      wIdx   <= bus.aw_addr[ADDR_W-1:OFFS];
      wLeft  <= bus.aw_len;
      wIdReg <= bus.aw_id;
      wErr   <= 1'b0;
    end else if (wHs) begin
      wIdx  <= wIdx + IDX_W'(1);
      wLeft <= wLeft - 8'd1;
      wErr  <= wErr | wBeatErr;
    end
  end

  assign bus.b_resp = (bus.b_valid & wErr) ? RESP_SLVERR : RESP_OKAY;
  assign bus.b_id   = wIdReg;

  // Read path: the RAM is fetched on the address handshake and on each
  // accepted non-final beat, so its output register holds steady under stall.
  assign rLastBeat = (rLeft == 8'd0);
  assign rdIdxNext = arHs ? bus.ar_addr[ADDR_W-1:OFFS] : rIdx + IDX_W'(1);
  assign ramRdEn   = arHs | (rHs & ~rLastBeat);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rIdx   <= '0;
      rOob   <= 1'b0;
      rLeft  <= '0;
      rIdReg <= '0;
    end else begin
      if (ramRdEn) begin
        rIdx <= rdIdxNext;
        rOob <= (rdIdxNext >= LIMIT);
      end
      if (arHs) begin
        rLeft  <= bus.ar_len;
        rIdReg <= bus.ar_id;
      end else if (rHs) begin
        rLeft <= rLeft - 8'd1;
      end
    end
  end

  assign bus.r_last = bus.r_valid & rLastBeat;
  assign bus.r_resp = (bus.r_valid & rOob) ? RESP_SLVERR : RESP_OKAY;
  assign bus.r_data = (bus.r_valid & ~rOob) ? ramRdData : '0;
  assign bus.r_id   = rIdReg;

  axi_mem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) ram (
    .clock (clock),
    .reset (reset),
    .wrEn  (ramWrEn),
    .wrAddr(wIdx[RAM_AW-1:0]),
    .wrData(bus.w_data),
    .wrStrb(bus.w_strb),
    .rdEn  (ramRdEn),
    .rdAddr(rdIdxNext[RAM_AW-1:0]),
    .rdData(ramRdData)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed bench for axi_mem_slave with a word-array memory model and read scoreboard.
// Also builds with AXI_MEM_SLAVE_BACKPRESSURE_EN, where readies are checked against an LFSR model.
module tb_axi_mem_slave;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  axi_mem_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rBeat_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mdl [DEPTH];
  rBeat_t      rdq [$];
  bit          wBusy = 0, inData = 0, rBusy = 0;
  int          wIdxM, wBeatM, wLenM;
  bit          wErrM;
  logic [3:0]  wIdM;
  logic [63:0] lastRData;
  logic [1:0]  lastRResp;
  logic        lastRLast;
  logic [1:0]  lastBResp;
  logic [3:0]  lastBId;
  logic        lfsrBitM;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef AXI_MEM_SLAVE_BACKPRESSURE_EN
  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1: feedback is the parity of taps at bits 0,2,3,5.
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    logic fb;
    fb = ^(s & 16'h002D);
    return {fb, s[15:1]};
  endfunction

  logic [15:0] lfsrM;
  always @(posedge clock or posedge reset) begin
    if (reset) lfsrM <= 16'hACE1;
    else lfsrM <= lfsrStep(lfsrM);
  end
  assign lfsrBitM = lfsrM[0];
`else
  assign lfsrBitM = 1'b1;
`endif

  function automatic logic [63:0] seqData(input int i);
    return 64'h0101010101010101 * 64'(i + 1);
  endfunction

  function automatic logic [63:0] longData(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h0000BEEF + 32'(i)};
  endfunction

  // Per-cycle compare: readies/valids against bench-tracked burst state, read beats against the scoreboard.
  initial begin
    bit          prevStall = 0;
    logic [63:0] prevData  = '0;
    logic        prevLast  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevStall = 0;
      end else begin
        check("aw_ready", 64'(bus.aw_ready), 64'(!wBusy && lfsrBitM));
        check("w_ready", 64'(bus.w_ready), 64'(inData && lfsrBitM));
        check("ar_ready", 64'(bus.ar_ready), 64'(!rBusy && lfsrBitM));
        check("b_valid", 64'(bus.b_valid), 64'(wBusy && !inData));
        check("r_valid", 64'(bus.r_valid), 64'(rBusy));
        if (prevStall) begin
          check("r_data_stable", bus.r_data, prevData);
          check("r_last_stable", 64'(bus.r_last), 64'(prevLast));
        end
        if (bus.r_valid) begin
          if (rdq.size() == 0) begin
            check("r_unexpected", 64'(bus.r_valid), 64'd0);
          end else begin
            check("r_data", bus.r_data, rdq[0].data);
            check("r_resp", 64'(bus.r_resp), 64'(rdq[0].resp));
            check("r_last", 64'(bus.r_last), 64'(rdq[0].last));
            check("r_id", 64'(bus.r_id), 64'(rdq[0].id));
            if (bus.r_ready) begin
              lastRData = bus.r_data;
              lastRResp = bus.r_resp;
              lastRLast = bus.r_last;
              void'(rdq.pop_front());
            end
          end
        end
        prevStall = bus.r_valid && !bus.r_ready;
        prevData  = bus.r_data;
        prevLast  = bus.r_last;
      end
    end
  end

  task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input int len);
    int guard = 0;
    bus.aw_valid = 1'b1; bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = 8'(len);
    do begin @(negedge clock); guard++; end while (!bus.aw_ready && guard < 100);
    if (!bus.aw_ready) check("aw_hs_timeout", 64'(bus.aw_ready), 64'd1);
    @(posedge clock); #1;
    bus.aw_valid = 1'b0;
    wBusy = 1; inData = 1;
    wIdxM = int'(addr >> 3); wBeatM = 0; wLenM = len; wErrM = 0; wIdM = id;
  endtask

  task automatic sendBeat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int guard = 0;
    bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb; bus.w_last = last;
    do begin @(negedge clock); guard++; end while (!bus.w_ready && guard < 100);
    if (!bus.w_ready) check("w_hs_timeout", 64'(bus.w_ready), 64'd1);
    @(posedge clock); #1;
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    if (wIdxM >= DEPTH) wErrM = 1;
    else for (int b = 0; b < 8; b++) if (strb[b]) mdl[wIdxM][b*8 +: 8] = data[b*8 +: 8];
    if (last != (wBeatM == wLenM)) wErrM = 1;
    if (wBeatM == wLenM) inData = 0;
    wIdxM++; wBeatM++;
  endtask

  task automatic waitB();
    int guard = 0;
    bus.b_ready = 1'b1;
    do begin @(negedge clock); guard++; end while (!bus.b_valid && guard < 100);
    check("b_hs", 64'(bus.b_valid), 64'd1);
    check("b_resp", 64'(bus.b_resp), wErrM ? 64'd2 : 64'd0);
    check("b_id", 64'(bus.b_id), 64'(wIdM));
    lastBResp = bus.b_resp; lastBId = bus.b_id;
    @(posedge clock); #1;
    bus.b_ready = 1'b0;
    wBusy = 0;
  endtask

  task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input int len);
    int guard = 0;
    int idx = int'(addr >> 3);
    rBeat_t e;
    for (int k = 0; k <= len; k++) begin
      e.id = id; e.last = (k == len);
      if (idx + k >= DEPTH) begin e.data = '0; e.resp = 2'b10; end
      else begin e.data = mdl[idx + k]; e.resp = 2'b00; end
      rdq.push_back(e);
    end
    bus.ar_valid = 1'b1; bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = 8'(len);
    do begin @(negedge clock); guard++; end while (!bus.ar_ready && guard < 100);
    if (!bus.ar_ready) check("ar_hs_timeout", 64'(bus.ar_ready), 64'd1);
    @(posedge clock); #1;
    bus.ar_valid = 1'b0;
    rBusy = 1;
  endtask

  task automatic drainRead(input bit toggle);
    int guard = 0;
    bit done = 0;
    while (!done && guard < 300) begin
      bus.r_ready = toggle ? guard[0] : 1'b1;
      @(negedge clock);
      if (bus.r_valid && bus.r_ready && bus.r_last) done = 1;
      @(posedge clock); #1;
      guard++;
    end
    if (!done) check("r_drain_timeout", 64'(done), 64'd1);
    bus.r_ready = 1'b0;
    rBusy = 0;
    check("r_queue_empty", 64'(rdq.size()), 64'd0);
  endtask

  task automatic doWrite(input logic [3:0] id, input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    sendAw(id, addr, 0);
    sendBeat(data, strb, 1'b1);
    waitB();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
    bus.b_ready = 0; bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0;
    bus.ar_len = '0; bus.r_ready = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    check("rst_w_ready", 64'(bus.w_ready), 64'd0);
    check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_b_resp", 64'(bus.b_resp), 64'd0);
    check("rst_r_resp", 64'(bus.r_resp), 64'd0);
    check("rst_r_last", 64'(bus.r_last), 64'd0);
    check("rst_r_data", bus.r_data, 64'd0);
    check("rst_b_id", 64'(bus.b_id), 64'd0);
    check("rst_r_id", 64'(bus.r_id), 64'd0);
    reset = 1'b0;

    // single-beat write and readback
    doWrite(4'h3, 32'h0, 64'hfedcba9876543210, 8'hFF);
    check("t1_b_resp_lit", 64'(lastBResp), 64'd0);
    check("t1_b_id_lit", 64'(lastBId), 64'd3);
    sendAr(4'h5, 32'h0, 0);
    drainRead(1'b0);
    check("t1_r_data_lit", lastRData, 64'hfedcba9876543210);
    check("t1_r_last_lit", 64'(lastRLast), 64'd1);

    // 4-beat burst, read back with r_ready toggling
    sendAw(4'h1, 32'h20, 3);
    for (int i = 0; i < 4; i++) sendBeat(seqData(i), 8'hFF, 1'(i == 3));
    waitB();
    sendAr(4'h2, 32'h20, 3);
    drainRead(1'b1);
    check("t2_r_data_lit", lastRData, 64'h0404040404040404);

    // partial strobe over a zeroed word
    doWrite(4'h4, 32'h50, 64'h0, 8'hFF);
    doWrite(4'h4, 32'h50, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    sendAr(4'h4, 32'h50, 0);
    drainRead(1'b0);
    check("t3_r_data_lit", lastRData, 64'h00000000FFFFFFFF);

    // out-of-range word index DEPTH
    sendAr(4'h6, 32'h800, 0);
    drainRead(1'b0);
    check("t4_r_resp_lit", 64'(lastRResp), 64'd2);
    check("t4_r_data_lit", lastRData, 64'd0);
    doWrite(4'h6, 32'h800, 64'h1111111111111111, 8'hFF);
    check("t4_b_resp_lit", 64'(lastBResp), 64'd2);
    sendAr(4'h6, 32'h0, 0);
    drainRead(1'b0);
    check("t4_word0_lit", lastRData, 64'hfedcba9876543210);

    // w_last early then missing: burst still ends on beat count, SLVERR
    sendAw(4'h7, 32'h60, 1);
    sendBeat(64'hAAAA0000AAAA0000, 8'hFF, 1'b1);
    sendBeat(64'hBBBB0000BBBB0000, 8'hFF, 1'b0);
    waitB();
    check("t5_b_resp_lit", 64'(lastBResp), 64'd2);
    sendAr(4'h7, 32'h60, 1);
    drainRead(1'b0);
    check("t5_r_data_lit", lastRData, 64'hBBBB0000BBBB0000);

`ifndef AXI_MEM_SLAVE_BACKPRESSURE_EN
    // read and write of word 12 on the same edge returns pre-write data
    sendAw(4'h8, 32'h60, 0);
    fork
      sendBeat(64'h5555555555555555, 8'hFF, 1'b1);
      sendAr(4'h9, 32'h60, 0);
    join
    fork
      waitB();
      drainRead(1'b0);
    join
    check("t6_prewrite_lit", lastRData, 64'hAAAA0000AAAA0000);
    sendAr(4'h9, 32'h60, 0);
    drainRead(1'b0);
    check("t6_postwrite_lit", lastRData, 64'h5555555555555555);
`endif

    // 16-beat burst
    sendAw(4'hA, 32'h100, 15);
    for (int i = 0; i < 16; i++) sendBeat(longData(i), 8'hFF, 1'(i == 15));
    waitB();
    sendAr(4'hB, 32'h100, 15);
    drainRead(1'b0);
    check("t7_r_data_lit", lastRData, 64'hC0DE000F0000BEFE);

    // reset in the middle of an 8-beat read
    sendAr(4'hC, 32'h100, 7);
    bus.r_ready = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("t8_r_valid_in_rst", 64'(bus.r_valid), 64'd0);
    check("t8_r_data_in_rst", bus.r_data, 64'd0);
    check("t8_ar_ready_in_rst", 64'(bus.ar_ready), 64'd0);
    rdq.delete();
    rBusy = 0;
    bus.r_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t8_ar_ready_release", 64'(bus.ar_ready), 64'd1);
    @(posedge clock); #1;
    sendAr(4'hD, 32'h100, 15);
    drainRead(1'b1);
    check("t8_retained_lit", lastRData, 64'hC0DE000F0000BEFE);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
